// File: rtl/mod_n_pkg.sv
// Shared types and helpers for the mod-N sequence checker.
// Holds the checker state encoding and the successor function of the count sequence.
package mod_n_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Successor of x in the sequence 0,1,..,mod-1,0,...
  function automatic logic [31:0] next_val(input logic [31:0] x, input logic [31:0] mod);
    return (x == mod - 32'd1) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/mod_n_sequence_checker_sat_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with an
// increment leaves the count at one so that event is not lost.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] value
);

  localparam logic [ERR_W-1:0] MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= inc ? ERR_W'(1) : '0;
    end else if (inc && value != MAX) begin
      value <= value + ERR_W'(1);
    end
  end

endmodule

// File: rtl/mod_n_sequence_checker.sv
// Protocol monitor for a mod-N count stream: hunts for a legal value, confirms
// LOCK_CNT consecutive successors, then flags every break in the sequence.
module mod_n_sequence_checker
  import mod_n_pkg::*;
#(
  parameter int MOD      = 3,
  parameter int WIDTH    = 2,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  // One extra bit so MOD == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_V = (WIDTH + 1)'(MOD);

  chk_state_t       state, state_next;
  logic [RUN_W-1:0] run, run_next, run_inc;
  logic [WIDTH-1:0] expected_next, succ;
  logic             legal, match, err_det;

  assign legal   = {1'b0, in_count} < MOD_V;
  assign match   = legal && (in_count == expected);
  assign succ    = WIDTH'(next_val(32'(in_count), 32'(MOD)));
  assign run_inc = run + RUN_W'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    run_next      = run;
    expected_next = expected;
    err_det       = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (legal) begin
            expected_next = succ;
            run_next      = RUN_W'(1);
            state_next    = (LOCK_CNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (!legal) begin
            state_next = HUNT;
            run_next   = '0;
          end else if (match) begin
            expected_next = succ;
            run_next      = run_inc;
            if (run_inc == RUN_W'(LOCK_CNT)) state_next = LOCKED;
          end else begin
            // Any legal value restarts the candidate run rather than dropping to HUNT.
            expected_next = succ;
            run_next      = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            expected_next = succ;
          end else begin
            err_det    = 1'b1;
            state_next = HUNT;
            run_next   = '0;
          end
        end
        default: begin
          state_next = HUNT;
          run_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      run       <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      expected  <= expected_next;
      locked    <= (state_next == LOCKED);
      err_pulse <= err_det;
    end
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_det),
    .clr   (clear_err),
    .value (err_count)
  );

endmodule

// File: tb/tb_mod_n_sequence_checker.sv
// Self-checking bench: two checker instances (ERR_W=8 and ERR_W=2) share one
// stimulus stream and are compared against a behavioural model of the sequence rules.
module tb_mod_n_sequence_checker;

  localparam int MOD      = 3;
  localparam int WIDTH    = 2;
  localparam int LOCK_CNT = 3;
  localparam int SAT_MAX  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_count = '0;
  logic             clear_err = 1'b0;

  logic             locked, err_pulse;
  logic [7:0]       err_count;
  logic [WIDTH-1:0] expected;
  logic             s_locked, s_pulse;
  logic [1:0]       s_count;
  logic [WIDTH-1:0] s_expected;

  mod_n_sequence_checker #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count), .clear_err(clear_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  mod_n_sequence_checker #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count), .clear_err(clear_err),
    .locked(s_locked), .err_pulse(s_pulse), .err_count(s_count), .expected(s_expected)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: "hunting" means unlocked with no candidate run.
  bit m_locked;
  int m_run;
  int m_exp;
  int m_errs;
  int m_errs_sat;
  bit m_pulse;

  function automatic int succ_of(int x);
    return (x + 1) % MOD;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_exp = 0; m_errs = 0; m_errs_sat = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    bit err = 0;
    bit ok  = (c < MOD);
    if (v) begin
      if (m_locked) begin
        if (ok && c == m_exp) m_exp = succ_of(c);
        else begin err = 1; m_locked = 0; m_run = 0; end
      end else if (m_run == 0) begin
        if (ok) begin m_exp = succ_of(c); m_run = 1; m_locked = (LOCK_CNT == 1); end
      end else if (!ok) begin
        m_run = 0;
      end else if (c == m_exp) begin
        m_run++; m_exp = succ_of(c);
        if (m_run == LOCK_CNT) m_locked = 1;
      end else begin
        m_run = 1; m_exp = succ_of(c);
      end
    end
    m_pulse = err;
    if (clr) begin
      m_errs = err; m_errs_sat = err;
    end else if (err) begin
      if (m_errs < 255) m_errs++;
      if (m_errs_sat < SAT_MAX) m_errs_sat++;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, return #1 after it.
  task automatic step(input bit v, input int c, input bit clr);
    @(negedge clk);
    in_valid = v; in_count = WIDTH'(c); clear_err = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; clear_err = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (locked !== 1'b0) begin n_miss++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_vec++; if (err_pulse !== 1'b0) begin n_miss++; $display("FAIL reset_pulse: got %0b want 0", err_pulse); end
    n_vec++; if (err_count !== 8'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", err_count); end
    n_vec++; if (expected !== '0) begin n_miss++; $display("FAIL reset_expected: got %0d want 0", expected); end
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  task automatic test_lock();
    int seq[3] = '{0, 1, 2};
    for (int i = 0; i < 3; i++) begin
      step(1, seq[i], 0);
      n_vec++; if (locked !== m_locked) begin n_miss++; $display("FAIL lock_locked[%0d]: got %0b want %0b", i, locked, m_locked); end
      n_vec++; if (err_pulse !== 1'b0) begin n_miss++; $display("FAIL lock_pulse[%0d]: got %0b want 0", i, err_pulse); end
      n_vec++; if (expected !== WIDTH'(m_exp)) begin n_miss++; $display("FAIL lock_expected[%0d]: got %0d want %0d", i, expected, m_exp); end
    end
    n_vec++; if (locked !== 1'b1) begin n_miss++; $display("FAIL lock_final: got %0b want 1", locked); end
  endtask

  task automatic test_error_relock();
    int seq[8] = '{0, 1, 2, 0, 2, 0, 1, 2};
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0);
      n_vec++; if (locked !== m_locked) begin n_miss++; $display("FAIL relock_locked[%0d]: got %0b want %0b", i, locked, m_locked); end
      n_vec++; if (err_pulse !== m_pulse) begin n_miss++; $display("FAIL relock_pulse[%0d]: got %0b want %0b", i, err_pulse, m_pulse); end
      n_vec++; if (err_count !== 8'(m_errs)) begin n_miss++; $display("FAIL relock_count[%0d]: got %0d want %0d", i, err_count, m_errs); end
    end
    n_vec++; if (err_count !== 8'd1 || locked !== 1'b1) begin
      n_miss++; $display("FAIL relock_final: count=%0d locked=%0b want 1/1", err_count, locked);
    end
  endtask

  task automatic test_gaps();
    bit vs[9] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    int cs[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 2};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(vs[i], vs[i] ? cs[i] : $urandom_range(0, 3), 0);
      n_vec++; if (locked !== m_locked) begin n_miss++; $display("FAIL gap_locked[%0d]: got %0b want %0b", i, locked, m_locked); end
      n_vec++; if (err_pulse !== 1'b0) begin n_miss++; $display("FAIL gap_pulse[%0d]: got %0b want 0", i, err_pulse); end
      n_vec++; if (expected !== WIDTH'(m_exp)) begin n_miss++; $display("FAIL gap_expected[%0d]: got %0d want %0d", i, expected, m_exp); end
    end
    n_vec++; if (locked !== 1'b1) begin n_miss++; $display("FAIL gap_final: got %0b want 1", locked); end
  endtask

  task automatic test_illegal();
    step(1, 0, 0);
    step(1, 3, 0);
    n_vec++; if (err_pulse !== 1'b1 || locked !== 1'b0) begin
      n_miss++; $display("FAIL illegal_locked: pulse=%0b locked=%0b want 1/0", err_pulse, locked);
    end
    n_vec++; if (err_count !== 8'(m_errs)) begin n_miss++; $display("FAIL illegal_count: got %0d want %0d", err_count, m_errs); end
    for (int i = 0; i < 2; i++) begin
      step(1, 3, 0);
      n_vec++; if (err_pulse !== 1'b0 || err_count !== 8'(m_errs) || locked !== 1'b0) begin
        n_miss++; $display("FAIL illegal_hunt[%0d]: pulse=%0b count=%0d locked=%0b want 0/%0d/0", i, err_pulse, err_count, locked, m_errs);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int e = 0; e < 6; e++) begin
      step(1, 0, 0); step(1, 1, 0); step(1, 2, 0);
      step(1, 1, (e == 5));
      n_vec++; if (s_pulse !== 1'b1) begin n_miss++; $display("FAIL sat_pulse[%0d]: got %0b want 1", e, s_pulse); end
      n_vec++; if (s_count !== 2'(m_errs_sat)) begin n_miss++; $display("FAIL sat_count[%0d]: got %0d want %0d", e, s_count, m_errs_sat); end
      n_vec++; if (err_count !== 8'(m_errs)) begin n_miss++; $display("FAIL sat_wide[%0d]: got %0d want %0d", e, err_count, m_errs); end
      if (e == 4) begin
        n_vec++; if (s_count !== 2'd3) begin n_miss++; $display("FAIL sat_stop: got %0d want 3", s_count); end
      end
    end
    n_vec++; if (s_count !== 2'd1 || err_count !== 8'd1) begin
      n_miss++; $display("FAIL sat_clear_err: sat=%0d wide=%0d want 1/1", s_count, err_count);
    end
    step(1, 0, 1);
    n_vec++; if (err_count !== 8'd0) begin n_miss++; $display("FAIL clear_only: got %0d want 0", err_count); end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0); step(1, 2, 0); step(1, 0, 0); step(1, 1, 0);
    n_vec++; if (locked !== 1'b1) begin n_miss++; $display("FAIL areset_pre: got %0b want 1", locked); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0 || expected !== '0) begin
      n_miss++; $display("FAIL areset_now: locked=%0b pulse=%0b count=%0d exp=%0d want 0/0/0/0", locked, err_pulse, err_count, expected);
    end
    model_reset();
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(1, 1, 0); step(1, 2, 0); step(1, 0, 0);
    n_vec++; if (locked !== 1'b1 || expected !== WIDTH'(1)) begin
      n_miss++; $display("FAIL areset_relock: locked=%0b exp=%0d want 1/1", locked, expected);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      int c   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : m_exp;
      bit clr = ($urandom_range(0, 31) == 0);
      step(v, c, clr);
      n_vec++; if (locked !== m_locked) begin n_miss++; $display("FAIL rnd_locked[%0d]: got %0b want %0b", i, locked, m_locked); end
      n_vec++; if (err_pulse !== m_pulse) begin n_miss++; $display("FAIL rnd_pulse[%0d]: got %0b want %0b", i, err_pulse, m_pulse); end
      n_vec++; if (err_count !== 8'(m_errs)) begin n_miss++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, err_count, m_errs); end
      n_vec++; if (expected !== WIDTH'(m_exp)) begin n_miss++; $display("FAIL rnd_expected[%0d]: got %0d want %0d", i, expected, m_exp); end
      n_vec++; if (s_count !== 2'(m_errs_sat)) begin n_miss++; $display("FAIL rnd_sat[%0d]: got %0d want %0d", i, s_count, m_errs_sat); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_error_relock();
    test_gaps();
    test_illegal();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mod_n_sequence_checker.md
Name: mod_n_sequence_checker

Overview:
- Receive-side companion to the team's mod-N counter FSM: consumes a count stream (0,1,..,MOD-1,0,...), locks onto it, then checks every later sample against the expected successor.
- Reports lock status, a one-cycle error pulse and a saturating error count.
- Sits downstream of any counter/FSM output as a protocol monitor.

Parameters:
- MOD, 3, modulus of the checked sequence; legal values 0..MOD-1; MOD >= 2
- WIDTH, 2, width of in_count; 2**WIDTH >= MOD
- LOCK_CNT, 3, consecutive correct samples required to declare lock; >= 1
- ERR_W, 8, width of err_count

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- in_valid  input  1  in_count is sampled this cycle when high
- in_count  input  WIDTH  observed counter value
- clear_err  input  1  synchronous clear of err_count
- locked  output  1  registered; high while in LOCKED
- err_pulse  output  1  registered; one-cycle pulse per detected error
- err_count  output  ERR_W  registered; saturating error total
- expected  output  WIDTH  registered; value the next valid sample must carry

Behaviour:
- Reset (rst low, any time, mid-operation included): state HUNT; locked=0, err_pulse=0, err_count=0, expected=0, run=0. Release is synchronous to the next rising edge.
- next(x) = (x == MOD-1) ? 0 : x+1. Sample is illegal if in_count >= MOD.
- in_valid low: state, run, expected, locked and err_count hold; err_pulse=0 next cycle.
- HUNT, valid sample:
  - Legal: expected<=next(in_count), run<=1, go SYNC; if LOCK_CNT==1 go LOCKED directly.
  - Illegal: stay HUNT, no error.
- SYNC, valid sample:
  - in_count==expected: run<=run+1, expected<=next(in_count); when run+1==LOCK_CNT go LOCKED.
  - Legal mismatch: restart, run<=1, expected<=next(in_count), stay SYNC.
  - Illegal: go HUNT, run<=0.
  - No error is reported in SYNC.
- LOCKED, valid sample:
  - Match: expected<=next(in_count).
  - Mismatch or illegal: err_pulse=1 for one cycle, err_count increments, go HUNT, locked=0, run<=0.
- Output timing: locked rises in the cycle after the LOCK_CNT-th correct sample and falls in the cycle after the erroring sample, together with err_pulse.
- err_count saturates at 2**ERR_W-1 and never wraps. err_pulse still fires while saturated.
- clear_err and an error in the same cycle: err_count<=1. clear_err alone: err_count<=0.
- Wrap-around MOD-1 -> 0 is a match, not an error.
- Back-to-back valid samples are accepted every cycle; throughput 1 sample/cycle.

Decomposition:
- Package mod_n_pkg: enum chk_state_t {HUNT, SYNC, LOCKED} (2-bit) and a next-value function parameterised on MOD.
- One natural sub-module: sat_counter (ERR_W, inc, clr, value), reused for err_count.
- Remaining FSM, run counter and expected register stay in the top module.

Test Plan:
- Reset then valid 0,1,2 (MOD=3, LOCK_CNT=3) -> locked=1 in the cycle after the third sample; expected=0; err_pulse never high.
- Locked stream 0,1,2,0,2 -> at the 2 (expected 1): err_pulse=1 for one cycle, err_count=1, locked=0; next samples 0,1,2 relock.
- in_valid gaps: 0, idle 5 cycles, 1, idle, 2 -> locks exactly as the gap-free stream; no error.
- Illegal value 3 while locked -> error counted; 3 while in HUNT -> stays HUNT, err_count unchanged.
- ERR_W=2 with 5 induced errors -> err_count stops at 3; err_pulse fires all 5 times; clear_err coinciding with the 6th error -> err_count=1.
- rst driven low mid-stream between clock edges while locked -> outputs go to 0 immediately, without waiting for a clock edge; stream 1,2,0 after release locks from HUNT.
